opcode_map: RTL and testbench
=============================

OPCODE_MAP -- requirements
Module: opcode_map

Interface
REQ-001 Parameter IR_W, default 8, instruction register width.
REQ-002 Parameter ADDR_W, default 5, microcode address width.
REQ-003 Parameter ILLEGAL_ADDR, default 31, microcode address emitted for undefined encodings.
REQ-004 Port clk input 1: single clock, all state updates on rising edge.
REQ-005 Port rst input 1: reset, synchronous and active-high.
REQ-006 Port ir input IR_W: instruction register contents to decode.
REQ-007 Port out output ADDR_W: registered microcode start address for the decoded instruction.
REQ-008 Port illegal output 1: registered flag, high when the captured ir is an undefined encoding.

Function
REQ-009 Valid encoding SHALL be ir[3:0]==0; the opcode SHALL be ir[7:4].
REQ-010 Opcode-to-address map SHALL be:
- 0 RSTALL->0, 1 CONST->1, 2 MOV->3, 3 SIZE->5
- 4 SUB->6, 5 JMPNZ->7, 6 MOV02->9, 7 ADDX->10
- 8 ADDY->11, 9 MUL->12, 10 ADD->13, 11 LOAD->14
- 12 MOV13->16, 13 INCI->17, 14 STORE->18, 15 RSTI->20
REQ-011 Any ir with ir[3:0]!=0 SHALL give out=ILLEGAL_ADDR and illegal=1; valid encodings SHALL give illegal=0.
REQ-012 out and illegal SHALL be registered and reflect the ir sampled at the previous rising edge, i.e. 1-cycle latency.
REQ-013 Decode SHALL be evaluated every cycle with no enable; holding ir constant SHALL hold out constant.
REQ-014 Repeated identical opcodes on consecutive cycles SHALL produce the same address every cycle, with no glitch and no toggle.
REQ-015 X or Z on any ir bit SHALL be treated as an undefined encoding (ILLEGAL_ADDR, illegal=1).
REQ-016 The decode SHALL be a pure function of ir, with no dependence on history.

Reset
REQ-017 While rst=1 at a rising edge, out SHALL become 0 (RSTALL address) and illegal SHALL become 0.
REQ-018 Reset SHALL take priority over decode; the first edge with rst=0 SHALL capture the current ir.
REQ-019 Asserting reset mid-stream SHALL discard the pending decode, with no partial update.

Structure
REQ-020 The opcode enumeration (RSTALL..RSTI, 4-bit) and the address constants of REQ-010 SHALL live in a shared package used by this block and the control-unit sequencer.
REQ-021 The block SHALL be one combinational decode function followed by an output register; no sub-module is required.

Verification
REQ-022 Assert rst for 2 cycles with ir=8'd32 -> out=0, illegal=0; release -> the next edge gives out=3.
REQ-023 Sweep ir=0,16,32,...,240, one per cycle -> out one cycle later = 0,1,3,5,6,7,9,10,11,12,13,14,16,17,18,20, with illegal=0.
REQ-024 Apply ir=8'd32 twice, then ir=8'd128 twice -> out stays 3 then 11 across the repeats, with no intermediate value.
REQ-025 Apply ir=8'd2, then ir=8'd241 -> out=31, illegal=1 for both; then ir=8'd144 -> out=12, illegal=0.
REQ-026 Assert rst while ir=8'd224 mid-sweep -> out=0 on that edge; deassert -> out=18 on the next edge.
REQ-027 Drive ir=8'bxxxx0000 -> out=31, illegal=1.

Source files
------------

// File: rtl/opcode_map_pkg.sv
// Shared opcode enumeration and microcode start addresses for the decoder and the
// control-unit sequencer.
package opcode_map_pkg;

  localparam int unsigned OpcodeW = 4;
  localparam int unsigned UaddrW  = 5;

  typedef enum logic [OpcodeW-1:0] {
    OpRstall = 4'd0,
    OpConst  = 4'd1,
    OpMov    = 4'd2,
    OpSize   = 4'd3,
    OpSub    = 4'd4,
    OpJmpnz  = 4'd5,
    OpMov02  = 4'd6,
    OpAddx   = 4'd7,
    OpAddy   = 4'd8,
    OpMul    = 4'd9,
    OpAdd    = 4'd10,
    OpLoad   = 4'd11,
    OpMov13  = 4'd12,
    OpInci   = 4'd13,
    OpStore  = 4'd14,
    OpRsti   = 4'd15
  } opcode_e;

  localparam logic [UaddrW-1:0] AddrRstall = 5'd0;
  localparam logic [UaddrW-1:0] AddrConst  = 5'd1;
  localparam logic [UaddrW-1:0] AddrMov    = 5'd3;
  localparam logic [UaddrW-1:0] AddrSize   = 5'd5;
  localparam logic [UaddrW-1:0] AddrSub    = 5'd6;
  localparam logic [UaddrW-1:0] AddrJmpnz  = 5'd7;
  localparam logic [UaddrW-1:0] AddrMov02  = 5'd9;
  localparam logic [UaddrW-1:0] AddrAddx   = 5'd10;
  localparam logic [UaddrW-1:0] AddrAddy   = 5'd11;
  localparam logic [UaddrW-1:0] AddrMul    = 5'd12;
  localparam logic [UaddrW-1:0] AddrAdd    = 5'd13;
  localparam logic [UaddrW-1:0] AddrLoad   = 5'd14;
  localparam logic [UaddrW-1:0] AddrMov13  = 5'd16;
  localparam logic [UaddrW-1:0] AddrInci   = 5'd17;
  localparam logic [UaddrW-1:0] AddrStore  = 5'd18;
  localparam logic [UaddrW-1:0] AddrRsti   = 5'd20;

  typedef struct packed {
    logic              valid;
    logic [UaddrW-1:0] addr;
  } decode_t;

  // An unknown opcode (X/Z bits) matches no item and comes back invalid.
  function automatic decode_t opcode_addr(input opcode_e op);
    decode_t d;
    d.valid = 1'b1;
    d.addr  = AddrRstall;
    case (op)
      OpRstall: d.addr = AddrRstall;
      OpConst:  d.addr = AddrConst;
      OpMov:    d.addr = AddrMov;
      OpSize:   d.addr = AddrSize;
      OpSub:    d.addr = AddrSub;
      OpJmpnz:  d.addr = AddrJmpnz;
      OpMov02:  d.addr = AddrMov02;
      OpAddx:   d.addr = AddrAddx;
      OpAddy:   d.addr = AddrAddy;
      OpMul:    d.addr = AddrMul;
      OpAdd:    d.addr = AddrAdd;
      OpLoad:   d.addr = AddrLoad;
      OpMov13:  d.addr = AddrMov13;
      OpInci:   d.addr = AddrInci;
      OpStore:  d.addr = AddrStore;
      OpRsti:   d.addr = AddrRsti;
      default:  d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/opcode_map_if.sv
// Instruction-in / microcode-address-out bus of the opcode decoder.
interface opcode_map_if #(
  parameter int unsigned IR_W   = 8,
  parameter int unsigned ADDR_W = 5
);
  logic [IR_W-1:0]   ir;
  logic [ADDR_W-1:0] out;
  logic              illegal;

  modport master (
    output ir,
    input  out,
    input  illegal
  );

  modport slave (
    input  ir,
    output out,
    output illegal
  );
endinterface

// File: rtl/opcode_map.sv
// Maps an instruction register to its microcode start address, one cycle later,
// flagging undefined encodings.
module opcode_map
  import opcode_map_pkg::*;
#(
  parameter int unsigned IR_W         = 8,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned ILLEGAL_ADDR = 31
) (
  input logic         clk,
  input logic         rst,
  opcode_map_if.slave bus
);

  logic [IR_W-1:0]   w_ir;
  decode_t           w_dec;
  logic [ADDR_W-1:0] w_out;
  logic              w_illegal;
  logic [ADDR_W-1:0] r_out;
  logic              r_illegal;

  assign w_ir = bus.ir;

  // Low nibble must be exactly zero; X/Z bits fall through to the illegal default.
  always_comb begin
    w_dec     = opcode_addr(opcode_e'(w_ir[7:4]));
    w_out     = ADDR_W'(ILLEGAL_ADDR);
    w_illegal = 1'b1;
    case (w_ir[3:0])
      4'h0: begin
        if (w_dec.valid) begin
          w_out     = ADDR_W'(w_dec.addr);
          w_illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out     <= ADDR_W'(AddrRstall);
      r_illegal <= 1'b0;
    end else begin
      r_out     <= w_out;
      r_illegal <= w_illegal;
    end
  end

  assign bus.out     = r_out;
  assign bus.illegal = r_illegal;

endmodule

// File: tb/tb_opcode_map.sv
// Scoreboard bench for opcode_map: expectations queued at drive time, popped after the edge.
module tb_opcode_map;

  typedef struct {
    string      tag;
    logic [4:0] addr;
    logic       illegal;
  } exp_t;

  localparam int unsigned ExpAddr [16] = '{0, 1, 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 16, 17,
                                           18, 20};

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  opcode_map_if #(.IR_W(8), .ADDR_W(5)) u_if ();

  opcode_map #(
    .IR_W        (8),
    .ADDR_W      (5),
    .ILLEGAL_ADDR(31)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input logic [7:0] v, input logic r);
    exp_t e;
    e.tag = tag;
    if (r) begin
      e.addr    = 5'd0;
      e.illegal = 1'b0;
    end else if ($isunknown(v) || v[3:0] != 4'h0) begin
      e.addr    = 5'd31;
      e.illegal = 1'b1;
    end else begin
      e.addr    = 5'(ExpAddr[v[7:4]]);
      e.illegal = 1'b0;
    end
    return e;
  endfunction

  // Drive on the falling edge, compare 1 ns after the next rising edge.
  task automatic step(input string tag, input logic [7:0] v, input logic r);
    exp_t e;
    @(negedge clk);
    u_if.ir = v;
    rst     = r;
    sb_q.push_back(model(tag, u_if.ir, r));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_out"}, 32'(u_if.out), 32'(e.addr));
      check({e.tag, "_ill"}, 32'(u_if.illegal), 32'(e.illegal));
    end
  endtask

  initial begin
    u_if.ir = 8'd32;
    step("rst0", 8'd32, 1'b1);
    step("rst1", 8'd32, 1'b1);
    step("rel", 8'd32, 1'b0);

    for (int i = 0; i < 16; i++) begin
      step($sformatf("sweep%0d", i), 8'(i * 16), 1'b0);
    end

    step("rep32a", 8'd32, 1'b0);
    step("rep32b", 8'd32, 1'b0);
    step("rep128a", 8'd128, 1'b0);
    step("rep128b", 8'd128, 1'b0);

    step("ill2", 8'd2, 1'b0);
    step("ill241", 8'd241, 1'b0);
    step("ok144", 8'd144, 1'b0);
    step("ill15", 8'd15, 1'b0);
    step("ill8", 8'd8, 1'b0);

    step("mid192", 8'd192, 1'b0);
    step("mid208", 8'd208, 1'b0);
    step("midrst", 8'd224, 1'b1);
    step("mid224", 8'd224, 1'b0);
    step("mid240", 8'd240, 1'b0);

    step("xhi", 8'bxxxx0000, 1'b0);
    step("after_x", 8'd16, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
